// File: rtl/ps2_device.sv
// PS/2 device endpoint: drives the bus clock, sends 11-bit frames to the host and
// receives host commands, finishing each with the acknowledge pulse.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | lines released, waiting for a tx handshake or host request-to-send
// S_TX_HIGH | clock released, current frame bit presented on data
// S_TX_LOW  | clock driven low, data held
// S_TX_END  | lines released for one half period before tx_done
// S_RX_LOW  | clock driven low while the host sets up the next bit
// S_RX_HIGH | clock released, data sampled mid-phase
// S_ACK     | data held low across one extra clock pulse
// S_RX_END  | waiting for the host to release the data line
module ps2_device #(
   parameter int SYSCLK         = 50,
   parameter int HALF_PERIOD_US = 40,
   parameter int IDLE_US        = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_abort,
   output logic [7:0] rx_data,
   output logic       rx_vld,
   output logic       rx_parity_err,
   output logic       rx_frame_err,
   output logic       busy,
   input  logic       ps2_data_i,
   output logic       ps2_data_w,
   output logic       ps2_data_o,
   input  logic       ps2_clk_i,
   output logic       ps2_clk_w,
   output logic       ps2_clk_o
);
   localparam int HALF     = SYSCLK * HALF_PERIOD_US;
   localparam int IDLE_CYC = SYSCLK * IDLE_US;
   localparam int TW       = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int IW       = $clog2(IDLE_CYC + 1);
   localparam logic [TW-1:0] HALF_M1  = TW'(HALF - 1);
   localparam logic [TW-1:0] HALF_MID = TW'(HALF / 2);
   // our own clock release takes a few cycles to come back through the synchronizer
   localparam logic [TW-1:0] SETTLE   = TW'(3);
   localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYC);

   typedef enum logic [2:0] {
      S_IDLE, S_TX_HIGH, S_TX_LOW, S_TX_END, S_RX_LOW, S_RX_HIGH, S_ACK, S_RX_END
   } state_t;

   state_t        state_q;
   logic          clk_meta_q, clk_s_q, data_meta_q, data_s_q;
   logic [IW-1:0] idle_cnt_q;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    bit_q;
   logic [9:0]    tx_sh_q;
   logic [9:0]    rx_sh_q;
   logic [7:0]    rx_data_q;
   logic          tx_done_q, tx_abort_q, rx_vld_q, rx_perr_q, rx_ferr_q;
   logic          clk_w_q, data_w_q;
   logic          tick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_meta_q  <= 1'b0;
         clk_s_q     <= 1'b0;
         data_meta_q <= 1'b0;
         data_s_q    <= 1'b0;
         idle_cnt_q  <= '0;
      end else begin
         clk_meta_q  <= ps2_clk_i;
         clk_s_q     <= clk_meta_q;
         data_meta_q <= ps2_data_i;
         data_s_q    <= data_meta_q;
         if (clk_s_q && data_s_q) begin
            if (idle_cnt_q < IDLE_MAX) idle_cnt_q <= idle_cnt_q + 1'b1;
         end else begin
            idle_cnt_q <= '0;
         end
      end
   end

   assign tick = (timer_q == HALF_M1);

   always_comb begin
      timer_d = timer_q + 1'b1;
      if (tick || state_q == S_IDLE || state_q == S_RX_END) timer_d = '0;
   end

   assign tx_ready = (state_q == S_IDLE) && data_s_q && (idle_cnt_q >= IDLE_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         bit_q      <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= 8'h00;
         tx_done_q  <= 1'b0;
         tx_abort_q <= 1'b0;
         rx_vld_q   <= 1'b0;
         rx_perr_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
         clk_w_q    <= 1'b0;
         data_w_q   <= 1'b0;
      end else begin
         tx_done_q  <= 1'b0;
         tx_abort_q <= 1'b0;
         rx_vld_q   <= 1'b0;
         rx_perr_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
         timer_q    <= timer_d;
         case (state_q)
            S_IDLE: begin
               if (!data_s_q && clk_s_q) begin
                  bit_q   <= '0;
                  clk_w_q <= 1'b1;
                  state_q <= S_RX_LOW;
               end else if (tx_valid && tx_ready) begin
                  tx_sh_q  <= {1'b1, ~^tx_data, tx_data};
                  bit_q    <= '0;
                  data_w_q <= 1'b1;
                  state_q  <= S_TX_HIGH;
               end
            end
            S_TX_HIGH: begin
               if (!clk_s_q && timer_q >= SETTLE && bit_q <= 4'd9) begin
                  tx_abort_q <= 1'b1;
                  clk_w_q    <= 1'b0;
                  data_w_q   <= 1'b0;
                  state_q    <= S_IDLE;
               end else if (tick) begin
                  clk_w_q <= 1'b1;
                  state_q <= S_TX_LOW;
               end
            end
            S_TX_LOW: begin
               if (tick) begin
                  clk_w_q <= 1'b0;
                  if (bit_q == 4'd10) begin
                     data_w_q <= 1'b0;
                     state_q  <= S_TX_END;
                  end else begin
                     bit_q    <= bit_q + 1'b1;
                     data_w_q <= ~tx_sh_q[0];
                     tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
                     state_q  <= S_TX_HIGH;
                  end
               end
            end
            S_TX_END: begin
               if (tick) begin
                  tx_done_q <= 1'b1;
                  state_q   <= S_IDLE;
               end
            end
            S_RX_LOW: begin
               if (tick) begin
                  clk_w_q <= 1'b0;
                  state_q <= S_RX_HIGH;
               end
            end
            S_RX_HIGH: begin
               if (timer_q == HALF_MID) rx_sh_q <= {data_s_q, rx_sh_q[9:1]};
               if (tick) begin
                  if (bit_q == 4'd9) begin
                     if (rx_sh_q[9]) begin
                        bit_q    <= '0;
                        clk_w_q  <= 1'b1;
                        data_w_q <= 1'b1;
                        state_q  <= S_ACK;
                     end else begin
                        rx_ferr_q <= 1'b1;
                        state_q   <= S_RX_END;
                     end
                  end else begin
                     bit_q   <= bit_q + 1'b1;
                     clk_w_q <= 1'b1;
                     state_q <= S_RX_LOW;
                  end
               end
            end
            S_ACK: begin
               if (tick) begin
                  if (bit_q == 4'd0) begin
                     clk_w_q <= 1'b0;
                     bit_q   <= 4'd1;
                  end else begin
                     data_w_q  <= 1'b0;
                     rx_data_q <= rx_sh_q[7:0];
                     rx_perr_q <= ~(^rx_sh_q[8:0]);
                     rx_vld_q  <= 1'b1;
                     state_q   <= S_RX_END;
                  end
               end
            end
            S_RX_END: begin
               if (data_s_q) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign tx_done       = tx_done_q;
   assign tx_abort      = tx_abort_q;
   assign rx_data       = rx_data_q;
   assign rx_vld        = rx_vld_q;
   assign rx_parity_err = rx_perr_q;
   assign rx_frame_err  = rx_ferr_q;
   assign busy          = (state_q != S_IDLE);
   assign ps2_clk_w     = clk_w_q;
   assign ps2_data_w    = data_w_q;
   assign ps2_clk_o     = 1'b0;
   assign ps2_data_o    = 1'b0;
endmodule

// File: tb/tb_ps2_device.sv
// Bench for ps2_device: open-drain bus with a behavioural host, directed and random
// frames in both directions, abort, collision and mid-frame reset.
module tb_ps2_device;
   localparam int HALF = 16;
   localparam int IDLE = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, tx_done, tx_abort, rx_vld, rx_parity_err, rx_frame_err, busy;
   logic [7:0] rx_data;
   logic       ps2_data_w, ps2_data_o, ps2_clk_w, ps2_clk_o;
   logic       host_clk_low = 1'b0;
   logic       host_data_low = 1'b0;
   wire        clk_line  = ~(ps2_clk_w | host_clk_low);
   wire        data_line = ~(ps2_data_w | host_data_low);

   int total = 0;
   int bad   = 0;

   ps2_device #(.SYSCLK(1), .HALF_PERIOD_US(HALF), .IDLE_US(IDLE)) dut (
      .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .tx_done(tx_done), .tx_abort(tx_abort),
      .rx_data(rx_data), .rx_vld(rx_vld), .rx_parity_err(rx_parity_err),
      .rx_frame_err(rx_frame_err), .busy(busy),
      .ps2_data_i(data_line), .ps2_data_w(ps2_data_w), .ps2_data_o(ps2_data_o),
      .ps2_clk_i(clk_line), .ps2_clk_w(ps2_clk_w), .ps2_clk_o(ps2_clk_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
      total++;
      assert (obs >= lo && obs <= hi) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   // line level the host sees at the k-th falling clock edge of a device frame
   function automatic logic frame_bit(input logic [7:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
      if (k == 9) return ($countones(d) % 2 == 0);
      return 1'b1;
   endfunction

   function automatic logic parity_bad(input logic [7:0] d, input logic par);
      return ((($countones(d) + int'(par)) % 2) == 0);
   endfunction

   task automatic tx_send(input logic [7:0] d);
      int cyc, w, edges, done_cyc;
      logic prev;
      tx_data  = d;
      tx_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (tx_ready !== 1'b1 && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("tx_ready_wait", tx_ready, 1'b1);
      @(posedge clk);
      #1 tx_valid = 1'b0;
      check("tx_ready_drop", tx_ready, 1'b0);
      check("tx_busy", busy, 1'b1);
      edges = 0;
      done_cyc = -1;
      prev = clk_line;
      for (cyc = 0; cyc <= 30 * HALF; cyc++) begin
         @(negedge clk);
         if (prev && !clk_line) begin
            if (edges <= 10) begin
               check($sformatf("tx_%02h_bit%0d", d, edges), data_line, frame_bit(d, edges));
               check_rng($sformatf("tx_edge%0d_time", edges), cyc,
                         HALF + 2*HALF*edges - 1, HALF + 2*HALF*edges + 1);
            end
            edges++;
         end
         prev = clk_line;
         if (tx_done) begin
            done_cyc = cyc;
            break;
         end
      end
      check("tx_edges", edges, 11);
      check_rng("tx_done_time", done_cyc, 23*HALF - 1, 23*HALF + 1);
      check("tx_released", {ps2_clk_w, ps2_data_w}, 2'b00);
   endtask

   task automatic rx_recv(input logic [7:0] d, input logic par, input logic stop,
                          input bit raise_valid, input logic [7:0] vbyte);
      int cyc, edges, first_edge, ack_cyc, vld_cyc, w;
      logic prev, ack_low, vld, ferr, late_vld;
      logic [7:0] got;
      logic perr;
      logic [9:0] bits;
      bits = {stop, par, d};
      edges = 0; first_edge = -1; ack_cyc = -1; vld_cyc = -1;
      ack_low = 1'b0; vld = 1'b0; ferr = 1'b0; got = 8'h00; perr = 1'b0;
      @(negedge clk);
      host_data_low = 1'b1;
      prev = clk_line;
      for (cyc = 1; cyc <= 30 * HALF; cyc++) begin
         @(negedge clk);
         if (raise_valid && cyc == 2) begin
            tx_data  = vbyte;
            tx_valid = 1'b1;
         end
         if (prev && !clk_line) begin
            edges++;
            if (edges == 1) first_edge = cyc;
            if (edges <= 10) host_data_low = ~bits[edges-1];
            if (edges == 11) begin
               ack_low = !data_line;
               ack_cyc = cyc;
            end
         end
         prev = clk_line;
         if (rx_vld) begin
            vld = 1'b1; vld_cyc = cyc; got = rx_data; perr = rx_parity_err;
            break;
         end
         if (rx_frame_err) begin
            ferr = 1'b1;
            break;
         end
      end
      check_rng("rx_first_clk", first_edge, 2, 4);
      if (stop) begin
         check("rx_vld", vld, 1'b1);
         check("rx_edges", edges, 11);
         check("rx_ack_low", ack_low, 1'b1);
         check_rng("rx_vld_time", vld_cyc - ack_cyc, 2*HALF - 1, 2*HALF + 1);
         check($sformatf("rx_data_%02h", d), got, d);
         check("rx_parity_err", perr, parity_bad(d, par));
         check("rx_no_ferr", ferr, 1'b0);
         w = 0;
         while (busy && w < 10) begin
            @(negedge clk);
            w++;
         end
         check("rx_back_idle", busy, 1'b0);
         check("rx_data_held", rx_data, d);
      end else begin
         check("rx_ferr", ferr, 1'b1);
         check("rx_ferr_edges", edges, 10);
         check("rx_ferr_no_vld", vld, 1'b0);
         late_vld = 1'b0;
         repeat (HALF) begin
            @(negedge clk);
            late_vld |= rx_vld | ~clk_line;
         end
         check("rx_ferr_no_ack", late_vld, 1'b0);
         check("rx_ferr_waits", busy, 1'b1);
         host_data_low = 1'b0;
         w = 0;
         while (busy && w < 10) begin
            @(negedge clk);
            w++;
         end
         check("rx_ferr_idle", busy, 1'b0);
      end
   endtask

   initial begin
      int edges, w, ab_cyc;
      logic prev, seen;
      logic [7:0] d;
      logic par;

      repeat (3) @(negedge clk);
      check("rst_clk_w", ps2_clk_w, 1'b0);
      check("rst_data_w", ps2_data_w, 1'b0);
      check("rst_tx_ready", tx_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_pulses", {tx_done, tx_abort, rx_vld, rx_parity_err, rx_frame_err}, 5'b0);
      check("rst_drive_vals", {ps2_clk_o, ps2_data_o}, 2'b00);
      rst = 1'b0;

      tx_send(8'h1C);
      rx_recv(8'hED, 1'b1, 1'b1, 1'b0, 8'h00);
      rx_recv(8'hED, 1'b0, 1'b1, 1'b0, 8'h00);
      rx_recv(8'hFF, 1'b1, 1'b0, 1'b0, 8'h00);

      // host inhibit while bit 5 is on the line
      tx_data = 8'hAA;
      tx_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (tx_ready !== 1'b1 && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("ab_ready", tx_ready, 1'b1);
      @(posedge clk);
      #1 tx_valid = 1'b0;
      edges = 0;
      prev = clk_line;
      for (int c = 0; c < 20 * HALF && edges < 5; c++) begin
         @(negedge clk);
         if (prev && !clk_line) edges++;
         prev = clk_line;
      end
      check("ab_edges", edges, 5);
      repeat (HALF + 6) @(negedge clk);
      host_clk_low = 1'b1;
      ab_cyc = -1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (tx_abort) begin
            ab_cyc = c;
            break;
         end
      end
      check_rng("ab_latency", ab_cyc, 1, 3);
      check("ab_released", {ps2_clk_w, ps2_data_w}, 2'b00);
      @(negedge clk);
      check("ab_pulse_1cyc", tx_abort, 1'b0);
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen |= tx_done | tx_ready;
      end
      host_clk_low = 1'b0;
      for (int c = 1; c <= IDLE + 4; c++) begin
         @(negedge clk);
         seen |= tx_done;
         if (c == IDLE - 2) check("ab_ready_early", tx_ready, 1'b0);
      end
      check("ab_ready_late", tx_ready, 1'b1);
      check("ab_no_done", seen, 1'b0);

      // request-to-send and tx_valid together: receive first, then the byte goes out
      rx_recv(8'h3C, 1'b1, 1'b1, 1'b1, 8'h5A);
      tx_send(8'h5A);

      for (int i = 0; i < 4; i++) begin
         d = 8'($urandom_range(0, 255));
         tx_send(d);
         d = 8'($urandom_range(0, 255));
         par = ($countones(d) % 2 == 0);
         if ($urandom_range(0, 1) == 1) par = ~par;
         rx_recv(d, par, 1'b1, 1'b0, 8'h00);
      end

      // reset in the middle of a receive
      @(negedge clk);
      host_data_low = 1'b1;
      edges = 0;
      prev = clk_line;
      for (int c = 0; c < 20 * HALF && edges < 4; c++) begin
         @(negedge clk);
         if (prev && !clk_line) edges++;
         prev = clk_line;
      end
      check("mrst_edges", edges, 4);
      check("mrst_clk_low", ps2_clk_w, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("mrst_release", {ps2_clk_w, ps2_data_w}, 2'b00);
      check("mrst_busy", busy, 1'b0);
      host_data_low = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (3 * HALF) begin
         @(negedge clk);
         seen |= rx_vld | rx_frame_err | tx_done;
      end
      check("mrst_no_pulse", seen, 1'b0);
      check("mrst_rx_data", rx_data, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
